// File: rtl/win_scanner_if.sv
// ---------------------------------------------------------------------------
// win_scanner_if
// Purpose : bundles the scan request, board read port and result signals
//           between the game controller / board memory and win_scanner.
// Signals : start        - scan request (controller -> scanner)
//           rd_en        - board read enable (scanner -> memory)
//           rd_addr[3:0] - board read address, row*3+col (scanner -> memory)
//           rd_data[1:0] - cell code, one cycle after rd_en (memory -> scanner)
//           busy         - scan in progress (READ or EVAL)
//           result_valid - one-cycle pulse when a result is ready
//           game_is_done - held: win or draw
//           winner[1:0]  - held winning symbol (10 X, 11 O, 00 none)
//           draw         - held: board full and no win
// Modports: slave  - the scanner side
//           master - the controller / memory side
// ---------------------------------------------------------------------------
interface win_scanner_if;
   logic       start;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy;
   logic       result_valid;
   logic       game_is_done;
   logic [1:0] winner;
   logic       draw;

   modport slave (
      input  start,
      input  rd_data,
      output rd_en,
      output rd_addr,
      output busy,
      output result_valid,
      output game_is_done,
      output winner,
      output draw
   );

   modport master (
      output start,
      output rd_data,
      input  rd_en,
      input  rd_addr,
      input  busy,
      input  result_valid,
      input  game_is_done,
      input  winner,
      input  draw
   );
endinterface

// File: rtl/win_scanner.sv
// ---------------------------------------------------------------------------
// win_scanner
// Purpose : post-move tic-tac-toe board evaluator. On start it reads the 9
//           board cells into a shadow copy, then checks the 8 winning lines
//           one per cycle and reports win / winner / draw.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high reset
//           bus   - win_scanner_if.slave (start, board read port, results)
// Params  : NUM_CELLS  - cells scanned (line table assumes 9)
//           EARLY_EXIT - 1: stop at the first winning line; 0: scan all 8
// Cell codes: 00 EMPTY, 10 X, 11 O, 01 illegal (treated as EMPTY).
// ---------------------------------------------------------------------------
module win_scanner #(
   parameter int NUM_CELLS  = 9,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic          clk,
   input logic          reset,
   win_scanner_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, EVAL, REPORT} stateT;

   // READ cycle index at which no read is issued and the last cell lands.
   localparam logic [3:0] LAST_READ = 4'(NUM_CELLS);

   stateT      state;
   stateT      stateNext;
   logic [3:0] readCnt;
   logic [2:0] lineIdx;
   logic [1:0] shadow [NUM_CELLS];
   logic       winFound;
   logic [1:0] winSym;
   logic [1:0] winnerQ;
   logic       drawQ;
   logic       doneQ;
   logic [3:0] idxA;
   logic [3:0] idxB;
   logic [3:0] idxC;
   logic [1:0] cellA;
   logic [1:0] cellB;
   logic [1:0] cellC;
   logic       lineWin;
   logic       boardFull;

   // Cell addresses of the line being evaluated this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      idxA = 4'd0;
      idxB = 4'd0;
      idxC = 4'd0;
      case (lineIdx)
         3'd0:    begin idxA = 4'd0; idxB = 4'd1; idxC = 4'd2; end
         3'd1:    begin idxA = 4'd3; idxB = 4'd4; idxC = 4'd5; end
         3'd2:    begin idxA = 4'd6; idxB = 4'd7; idxC = 4'd8; end
         3'd3:    begin idxA = 4'd0; idxB = 4'd3; idxC = 4'd6; end
         3'd4:    begin idxA = 4'd1; idxB = 4'd4; idxC = 4'd7; end
         3'd5:    begin idxA = 4'd2; idxB = 4'd5; idxC = 4'd8; end
         3'd6:    begin idxA = 4'd0; idxB = 4'd4; idxC = 4'd8; end
         default: begin idxA = 4'd2; idxB = 4'd4; idxC = 4'd6; end
      endcase
   end

   assign cellA = shadow[idxA];
   assign cellB = shadow[idxB];
   assign cellC = shadow[idxC];

   // Bit 1 set means X or O; EMPTY and the illegal code both have it clear,
   // so one bit serves both the win test and the full-board test.
   assign lineWin = cellA[1] && (cellA == cellB) && (cellA == cellC);

   always_comb begin
      boardFull = 1'b1;
      for (int i = 0; i < NUM_CELLS; i++) begin
         boardFull = boardFull & shadow[i][1];
      end
   end

   // Next-state and Moore outputs.
   always_comb begin
      stateNext        = state;
      bus.rd_en        = 1'b0;
      bus.rd_addr      = 4'd0;
      bus.busy         = 1'b0;
      bus.result_valid = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) stateNext = READ;
         end
         READ: begin
            bus.busy = 1'b1;
            if (readCnt < LAST_READ) begin
               bus.rd_en   = 1'b1;
               bus.rd_addr = readCnt;
            end
            if (readCnt == LAST_READ) stateNext = EVAL;
         end
         EVAL: begin
            bus.busy = 1'b1;
            if ((lineWin && EARLY_EXIT) || (lineIdx == 3'd7)) stateNext = REPORT;
         end
         REPORT: begin
            bus.result_valid = 1'b1;
            stateNext        = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Shadow board. Readdata for address i arrives at READ index i+1.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: this small register array is reset on purpose: its cleared
      // contents are a defined part of the post-reset state.
      if (reset) begin
         for (int i = 0; i < NUM_CELLS; i++) shadow[i] <= 2'b00;
      end else if ((state == READ) && (readCnt != 4'd0)) begin
         shadow[readCnt - 4'd1] <= bus.rd_data;
      end
   end

   // Sequencing counters, first-win capture and held results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readCnt  <= 4'd0;
         lineIdx  <= 3'd0;
         winFound <= 1'b0;
         winSym   <= 2'b00;
         winnerQ  <= 2'b00;
         drawQ    <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         readCnt <= (state == READ) ? readCnt + 4'd1 : 4'd0;
         lineIdx <= (state == EVAL) ? lineIdx + 3'd1 : 3'd0;

         // Only the first winning line in index order sets the winner.
         if (state == IDLE) begin
            winFound <= 1'b0;
            winSym   <= 2'b00;
         end else if ((state == EVAL) && lineWin && !winFound) begin
            winFound <= 1'b1;
            winSym   <= cellA;
         end

         // Held outputs change only when leaving REPORT.
         if (state == REPORT) begin
            winnerQ <= winFound ? winSym : 2'b00;
            drawQ   <= !winFound && boardFull;
            doneQ   <= winFound || boardFull;
         end
      end
   end

   assign bus.winner       = winnerQ;
   assign bus.draw         = drawQ;
   assign bus.game_is_done = doneQ;

endmodule

// File: tb/tb_win_scanner.sv
// ---------------------------------------------------------------------------
// tb_win_scanner
// Purpose : self-checking bench for win_scanner. Two instances (early exit
//           on and off) share one board memory and one start line; each has
//           its own registered read port model. Every cycle of every scan the
//           full output vector of both instances is compared against timing
//           and results derived from a line-table reference model.
// ---------------------------------------------------------------------------
module tb_win_scanner;

   logic clk = 1'b0;
   logic reset;
   logic start;

   always #5 clk = ~clk;

   win_scanner_if busE ();
   win_scanner_if busF ();

   assign busE.start = start;
   assign busF.start = start;

   win_scanner #(.NUM_CELLS(9), .EARLY_EXIT(1'b1)) dutE (
      .clk   (clk),
      .reset (reset),
      .bus   (busE.slave)
   );

   win_scanner #(.NUM_CELLS(9), .EARLY_EXIT(1'b0)) dutF (
      .clk   (clk),
      .reset (reset),
      .bus   (busF.slave)
   );

   logic [1:0] boardMem [9];

   // Registered board memory, one per read port; junk when not enabled so a
   // capture on the wrong cycle shows up.
   always @(posedge clk) begin
      if (busE.rd_en) busE.rd_data <= boardMem[busE.rd_addr];
      else            busE.rd_data <= 2'($urandom);
   end

   always @(posedge clk) begin
      if (busF.rd_en) busF.rd_data <= boardMem[busF.rd_addr];
      else            busF.rd_data <= 2'($urandom);
   end

   int total = 0;
   int bad   = 0;

   // Held results {winner, draw, game_is_done} currently expected.
   logic [3:0] heldE;
   logic [3:0] heldF;

   int lineTab [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                          '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: first winning line in table order, full-board test, held result.
   function automatic void refModel(output int winLine, output logic [3:0] held);
      logic [1:0] w;
      logic       full;
      logic       d;
      logic [1:0] a, b, c;
      w       = 2'b00;
      full    = 1'b1;
      winLine = -1;
      for (int k = 0; k < 8; k++) begin
         a = boardMem[lineTab[k][0]];
         b = boardMem[lineTab[k][1]];
         c = boardMem[lineTab[k][2]];
         if (winLine < 0 && (a == 2'b10 || a == 2'b11) && a == b && a == c) begin
            winLine = k;
            w       = a;
         end
      end
      for (int i = 0; i < 9; i++) begin
         if (!(boardMem[i] == 2'b10 || boardMem[i] == 2'b11)) full = 1'b0;
      end
      d    = (winLine < 0) && full;
      held = {w, d, (winLine >= 0) || d};
   endfunction

   function automatic logic [10:0] obsE();
      return {busE.rd_en, busE.rd_addr, busE.busy, busE.result_valid,
              busE.winner, busE.draw, busE.game_is_done};
   endfunction

   function automatic logic [10:0] obsF();
      return {busF.rd_en, busF.rd_addr, busF.busy, busF.result_valid,
              busF.winner, busF.draw, busF.game_is_done};
   endfunction

   // Expected output vector in cycle E+n of a scan whose result_valid is at E+lat.
   function automatic logic [10:0] expVec(input int n, input int lat,
                                          input logic [3:0] prev, input logic [3:0] nw);
      logic       en;
      logic [3:0] addr;
      en   = (n >= 1) && (n <= 9);
      addr = en ? 4'(n - 1) : 4'd0;
      return {en, addr, 1'(n < lat), 1'(n == lat), (n > lat) ? nw : prev};
   endfunction

   // Called with start already set ahead of edge E; returns in cycle E+20.
   task automatic runScan(input string name, input bit holdStart, input int poke);
      int         winLine;
      int         latE;
      logic [3:0] nw;
      refModel(winLine, nw);
      latE = (winLine >= 0) ? 12 + winLine : 19;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 1 && !holdStart) start = 1'b0;
         if (poke != 0 && n == poke) start = 1'b1;
         if (poke != 0 && n == poke + 1) start = 1'b0;
         check($sformatf("%s early c%0d", name, n), 16'(obsE()), 16'(expVec(n, latE, heldE, nw)));
         check($sformatf("%s full c%0d", name, n), 16'(obsF()), 16'(expVec(n, 19, heldF, nw)));
      end
      heldE = nw;
      heldF = nw;
   endtask

   task automatic setBoard(input logic [17:0] cells);
      for (int i = 0; i < 9; i++) boardMem[i] = cells[17 - 2*i -: 2];
   endtask

   task automatic randBoard();
      int r;
      int k;
      for (int i = 0; i < 9; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2)      boardMem[i] = 2'b00;
         else if (r < 3) boardMem[i] = 2'b01;
         else if (r < 7) boardMem[i] = 2'b10;
         else            boardMem[i] = 2'b11;
      end
      if ($urandom_range(0, 2) == 0) begin
         k = int'($urandom_range(0, 7));
         r = int'($urandom_range(2, 3));
         for (int j = 0; j < 3; j++) boardMem[lineTab[k][j]] = 2'(r);
      end
   endtask

   localparam logic [17:0] B_EMPTY = 18'b00_00_00_00_00_00_00_00_00;
   localparam logic [17:0] B_XROW  = 18'b10_10_10_00_00_00_00_00_00;
   localparam logic [17:0] B_ODIAG = 18'b10_10_11_11_11_10_11_10_10;
   localparam logic [17:0] B_DRAW  = 18'b10_11_10_10_11_11_11_10_10;
   localparam logic [17:0] B_DRAWI = 18'b10_11_10_10_11_11_11_10_01;
   localparam logic [17:0] B_XCOL  = 18'b00_10_00_00_10_11_00_10_11;
   localparam logic [17:0] B_OCOL  = 18'b00_00_11_10_00_11_00_10_11;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      heldE = 4'd0;
      heldF = 4'd0;
      setBoard(B_EMPTY);

      repeat (2) @(posedge clk);
      #1;
      check("in reset early", 16'(obsE()), 16'd0);
      check("in reset full", 16'(obsF()), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle early", 16'(obsE()), 16'd0);
      check("idle full", 16'(obsF()), 16'd0);

      // Directed boards; start poked mid-scan / during REPORT must be ignored.
      start = 1'b1; runScan("empty", 1'b0, 0);
      setBoard(B_XROW);  start = 1'b1; runScan("xrow", 1'b0, 12);
      setBoard(B_ODIAG); start = 1'b1; runScan("odiag", 1'b0, 5);
      setBoard(B_DRAW);  start = 1'b1; runScan("draw", 1'b0, 0);
      setBoard(B_DRAWI); start = 1'b1; runScan("draw01", 1'b0, 0);

      // start held high across three back-to-back scans.
      setBoard(B_DRAW);  start = 1'b1; runScan("hold0", 1'b1, 0);
      setBoard(B_EMPTY);               runScan("hold1", 1'b1, 0);
      setBoard(B_DRAW);                runScan("hold2", 1'b0, 0);

      // X win held, then reset in cycle E+7 of the next scan.
      setBoard(B_XCOL);  start = 1'b1; runScan("xcol", 1'b0, 0);
      start = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) start = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("mid reset early", 16'(obsE()), 16'd0);
      check("mid reset full", 16'(obsF()), 16'd0);
      @(posedge clk);
      #1;
      check("held reset early", 16'(obsE()), 16'd0);
      check("held reset full", 16'(obsF()), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      heldE = 4'd0;
      heldF = 4'd0;
      setBoard(B_OCOL);
      @(posedge clk);
      #1;
      start = 1'b1; runScan("after reset", 1'b0, 0);

      // Random boards.
      for (int t = 0; t < 30; t++) begin
         randBoard();
         start = 1'b1;
         runScan($sformatf("rand%0d", t), 1'b0,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
